// File: rtl/stack_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_guard_pkg
// Description : Shared definitions for the stack guard and the stack it
//               fronts: stack delta encodings, guard FSM state encoding,
//               default stack geometry, and the delta-forwarding helper.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_guard_pkg;

    // Default stack geometry, shared with the stack register file.
    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 19;      // head plus 18 tail entries
    localparam int DW_DEF    = 5;       // 2**DW_DEF must exceed DEPTH_DEF

    // Stack delta encodings as seen on the stack's delta input.
    typedef logic [1:0] delta_t;
    localparam delta_t D_NONE = 2'b00;
    localparam delta_t D_PUSH = 2'b01;
    localparam delta_t D_POP  = 2'b11;
    localparam delta_t D_ILL  = 2'b10;

    // Guard FSM states. ST_HALT is only reachable when the halt-on-fault
    // option is compiled in.
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // The stack has no meaning for the illegal encoding, so it is turned
    // into a no-op before it reaches the stack.
    function automatic delta_t fwd_delta(input delta_t d);
        return (d == D_ILL) ? D_NONE : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_guard_depth.sv
`default_nettype none
// ============================================================================
// Module      : stack_guard_depth
// Description : Saturating stack occupancy counter with high-water mark and
//               sticky overflow / underflow / illegal-delta fault flags.
// Ports       : clk, resetq       - clock, async active-low reset
//               op_valid_i        - upstream request consumed this cycle
//               op_delta_i        - delta of the consumed request
//               flush_pop_i       - flush sequencer pop (depth known > 0)
//               clr_faults_i      - clear flags, restart hwm at current depth
//               depth_o           - current occupancy
//               depth_next_o      - occupancy after this cycle's update
//               hwm_o             - high-water mark
//               ovf_o/unf_o/ill_o - sticky fault flags
// Revision    : 1.0 - initial release
// ============================================================================
module stack_guard_depth
    import stack_guard_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          resetq,
    input  logic          op_valid_i,
    input  logic [1:0]    op_delta_i,
    input  logic          flush_pop_i,
    input  logic          clr_faults_i,
    output logic [DW-1:0] depth_o,
    output logic [DW-1:0] depth_next_o,
    output logic [DW-1:0] hwm_o,
    output logic          ovf_o,
    output logic          unf_o,
    output logic          ill_o
);

    localparam logic [DW-1:0] C_DEPTH_MAX = DW'(DEPTH);

    logic [DW-1:0] depth_q, depth_d;
    logic [DW-1:0] hwm_q, hwm_d, hwm_base;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          ill_q, ill_d;
    logic          is_push, is_pop, at_full, at_empty;

    always_comb begin
        is_push  = op_valid_i && (op_delta_i == D_PUSH);
        is_pop   = (op_valid_i && (op_delta_i == D_POP)) || flush_pop_i;
        at_full  = (depth_q == C_DEPTH_MAX);
        at_empty = (depth_q == '0);

        // Out-of-range operations are still forwarded to the stack; only
        // the count saturates.
        depth_d = depth_q;
        if (is_push && !at_full) begin
            depth_d = depth_q + DW'(1);
        end else if (is_pop && !at_empty) begin
            depth_d = depth_q - DW'(1);
        end

        // A clear restarts tracking from the current depth; a same-cycle
        // push can still raise it immediately.
        hwm_base = clr_faults_i ? depth_q : hwm_q;
        hwm_d    = (depth_d > hwm_base) ? depth_d : hwm_base;

        // New faults take precedence over a same-cycle clear.
        ovf_d = (ovf_q && !clr_faults_i) || (is_push && at_full);
        unf_d = (unf_q && !clr_faults_i) || (is_pop && at_empty);
        ill_d = (ill_q && !clr_faults_i) || (op_valid_i && (op_delta_i == D_ILL));
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            depth_q <= '0;
            hwm_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            hwm_q   <= hwm_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ill_q   <= ill_d;
        end
    end

    assign depth_o      = depth_q;
    assign depth_next_o = depth_d;
    assign hwm_o        = hwm_q;
    assign ovf_o        = ovf_q;
    assign unf_o        = unf_q;
    assign ill_o        = ill_q;

endmodule
`default_nettype wire

// File: rtl/stack_guard.sv
`default_nettype none
// ============================================================================
// Module      : stack_guard
// Description : Guard between instruction decode and the stack register
//               file. Forwards stack operations, tracks occupancy, latches
//               sticky faults and a high-water mark, and sequences a flush
//               that pops the stack empty while stalling upstream.
// Options     : STACK_GUARD_HALT_EN - a consumed faulting request parks the
//               guard in HALT (stalled, stack idle) until clr_faults.
// Ports       : clk, resetq                  - clock, async active-low reset
//               req_we/req_delta/req_wd      - upstream stack request
//               stall                        - request not consumed
//               st_we/st_delta/st_wd         - to the stack
//               flush_req/busy/done          - flush control and status
//               clr_faults                   - clear flags and hwm
//               depth/hwm/ovf/unf/ill        - occupancy and fault status
// Revision    : 1.0 - initial release
// ============================================================================
module stack_guard
    import stack_guard_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             req_we,
    input  logic [1:0]       req_delta,
    input  logic [WIDTH-1:0] req_wd,
    output logic             stall,
    output logic             st_we,
    output logic [1:0]       st_delta,
    output logic [WIDTH-1:0] st_wd,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    input  logic             clr_faults,
    output logic [DW-1:0]    depth,
    output logic [DW-1:0]    hwm,
    output logic             ovf,
    output logic             unf,
    output logic             ill
);

    logic [1:0]    state_q, state_d;
    logic          consume;
    logic          flush_pop;
    logic [DW-1:0] depth_next;

`ifdef STACK_GUARD_HALT_EN
    localparam logic [DW-1:0] C_DEPTH_MAX = DW'(DEPTH);
    logic fault_ev;

    // Same conditions that set a fault flag for a request consumed in RUN.
    assign fault_ev = ((req_delta == D_PUSH) && (depth == C_DEPTH_MAX)) ||
                      ((req_delta == D_POP)  && (depth == '0)) ||
                      (req_delta == D_ILL);
`endif

    stack_guard_depth #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_depth (
        .clk          (clk),
        .resetq       (resetq),
        .op_valid_i   (consume),
        .op_delta_i   (req_delta),
        .flush_pop_i  (flush_pop),
        .clr_faults_i (clr_faults),
        .depth_o      (depth),
        .depth_next_o (depth_next),
        .hwm_o        (hwm),
        .ovf_o        (ovf),
        .unf_o        (unf),
        .ill_o        (ill)
    );

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        st_we      = req_we;
        st_delta   = fwd_delta(req_delta);
        st_wd      = req_wd;
        flush_busy = 1'b0;
        flush_done = 1'b0;
        consume    = 1'b0;
        flush_pop  = 1'b0;

        case (state_q)
            ST_RUN: begin
                consume = 1'b1;
                // The request accompanying flush_req is counted first, so
                // the flush length is taken from the updated depth.
                if (flush_req) begin
                    state_d = (depth_next != '0) ? ST_FLUSH : ST_DONE;
                end
`ifdef STACK_GUARD_HALT_EN
                if (fault_ev) begin
                    state_d = ST_HALT;
                end
`endif
            end
            ST_FLUSH: begin
                stall      = 1'b1;
                flush_busy = 1'b1;
                st_we      = 1'b0;
                st_delta   = D_POP;
                flush_pop  = 1'b1;
                if (depth == DW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                stall      = 1'b1;
                flush_done = 1'b1;
                st_we      = 1'b0;
                st_delta   = D_NONE;
                state_d    = ST_RUN;
            end
`ifdef STACK_GUARD_HALT_EN
            ST_HALT: begin
                stall    = 1'b1;
                st_we    = 1'b0;
                st_delta = D_NONE;
                if (clr_faults) begin
                    state_d = ST_RUN;
                end
            end
`endif
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
`default_nettype wire
